param_wrr_arbiter: RTL and testbench

PARAM_WRR_ARBITER -- requirements
Module: param_wrr_arbiter

---
 rtl/param_wrr_arbiter.sv | 127 ++++++++++++
 tb/tb_param_wrr_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/param_wrr_arbiter.sv
// Table-driven weighted round-robin arbiter: a schedule table of channel ids is
// scanned from a rotating pointer and the first non-empty channel wins one output word.
module param_wrr_arbiter #(
    parameter  int NCH   = 4,
    parameter  int DW    = 4,
    parameter  int DEPTH = 64,
    localparam int CW    = $clog2(NCH),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  init,
    input  logic [DEPTH*CW-1:0]   table_in,
    input  logic [NCH*DW-1:0]     data_in,
    input  logic [NCH-1:0]        empty,
    input  logic                  out_ready,
    output logic [NCH-1:0]        pop,
    output logic                  valid_out,
    output logic [DW-1:0]         data_out,
    output logic [CW-1:0]         grant_ch,
    output logic [PW-1:0]         slot_idx
);

    logic [CW-1:0]  tbl_q [DEPTH];
    logic [CW-1:0]  tbl_d [DEPTH];
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] pop_q, pop_d;
    logic           valid_q, valid_d;
    logic [DW-1:0]  data_q, data_d;
    logic [CW-1:0]  grant_ch_q, grant_ch_d;
    logic [PW-1:0]  slot_idx_q, slot_idx_d;

    logic [(1<<CW)-1:0] empty_ext;
    logic               found;
    logic [PW-1:0]      win_slot, scan_slot;
    logic [CW-1:0]      win_ch, scan_ch;
    logic [DW-1:0]      win_data;
    logic               grant;

    // Table entries >= NCH map onto padding bits forced to 1, so idle slots look empty.
    always_comb begin : winner_search
        empty_ext            = '1;
        empty_ext[NCH-1:0]   = empty;
        found                = 1'b0;
        win_slot             = '0;
        win_ch               = '0;
        scan_slot            = '0;
        scan_ch              = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_slot = ptr_q + PW'(i);
            scan_ch   = tbl_q[scan_slot];
            if (!found && !empty_ext[scan_ch]) begin
                found    = 1'b1;
                win_slot = scan_slot;
                win_ch   = scan_ch;
            end
        end
    end

    always_comb begin : data_mux
        win_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (win_ch == CW'(c)) begin
                win_data = data_in[c*DW +: DW];
            end
        end
    end

    assign grant = enb && !init && found && (!valid_q || out_ready);

    always_comb begin : next_state
        for (int k = 0; k < DEPTH; k++) begin
            tbl_d[k] = init ? table_in[k*CW +: CW] : tbl_q[k];
        end
        ptr_d      = ptr_q;
        pop_d      = '0;
        valid_d    = valid_q;
        data_d     = data_q;
        grant_ch_d = grant_ch_q;
        slot_idx_d = slot_idx_q;
        if (init) begin
            ptr_d   = '0;
            valid_d = 1'b0;
        end else if (grant) begin
            valid_d    = 1'b1;
            data_d     = win_data;
            grant_ch_d = win_ch;
            slot_idx_d = win_slot;
            pop_d      = NCH'(1) << win_ch;
            ptr_d      = win_slot + PW'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                tbl_q[k] <= CW'(k % NCH);
            end
            ptr_q      <= '0;
            pop_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            grant_ch_q <= '0;
            slot_idx_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                tbl_q[k] <= tbl_d[k];
            end
            ptr_q      <= ptr_d;
            pop_q      <= pop_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            grant_ch_q <= grant_ch_d;
            slot_idx_q <= slot_idx_d;
        end
    end

    assign pop       = pop_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign grant_ch  = grant_ch_q;
    assign slot_idx  = slot_idx_q;

endmodule

// File: tb/tb_param_wrr_arbiter.sv
// Bench for param_wrr_arbiter: directed scenarios followed by random traffic, all
// compared against a slot-scanning reference model of the schedule table.
module tb_param_wrr_arbiter;
    localparam int NCH   = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 2;
    localparam int PW    = 3;

    logic                clk0 = 1'b0;
    logic                rst = 1'b1;
    logic                enb = 1'b0;
    logic                init = 1'b0;
    logic                out_ready = 1'b0;
    logic [DEPTH*CW-1:0] table_in = '0;
    logic [NCH*DW-1:0]   data_in = '0;
    logic [NCH-1:0]      empty = '1;
    logic [NCH-1:0]      pop;
    logic                valid_out;
    logic [DW-1:0]       data_out;
    logic [CW-1:0]       grant_ch;
    logic [PW-1:0]       slot_idx;

    param_wrr_arbiter #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk0(clk0), .rst(rst), .enb(enb), .init(init),
        .table_in(table_in), .data_in(data_in), .empty(empty),
        .out_ready(out_ready), .pop(pop), .valid_out(valid_out),
        .data_out(data_out), .grant_ch(grant_ch), .slot_idx(slot_idx)
    );

    always #5 clk0 = ~clk0;

    int n_checks = 0;
    int n_pass   = 0;

    int m_tbl [DEPTH];
    int m_ptr, m_data, m_ch, m_slot, m_pop;
    bit m_valid;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) m_tbl[k] = k % NCH;
        m_ptr = 0; m_valid = 0; m_data = 0; m_ch = 0; m_slot = 0; m_pop = 0;
    endtask

    // Predicts the state after the coming edge from the inputs currently driven.
    task automatic model_step();
        bit found = 0;
        int ws = 0, wc = 0, s, ent;
        for (int i = 0; i < DEPTH; i++) begin
            s   = (m_ptr + i) % DEPTH;
            ent = m_tbl[s];
            if (!found && ent < NCH && empty[ent] == 1'b0) begin
                found = 1; ws = s; wc = ent;
            end
        end
        m_pop = 0;
        if (init) begin
            for (int k = 0; k < DEPTH; k++) m_tbl[k] = int'(table_in[k*CW +: CW]);
            m_ptr = 0; m_valid = 0;
        end else if (enb && found && (!m_valid || out_ready)) begin
            m_valid = 1;
            m_data  = int'(data_in[wc*DW +: DW]);
            m_ch    = wc;
            m_slot  = ws;
            m_pop   = 1 << wc;
            m_ptr   = (ws + 1) % DEPTH;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all(input string ctx);
        chk({ctx, ".pop"},      int'(pop),       m_pop);
        chk({ctx, ".valid"},    int'(valid_out), int'(m_valid));
        chk({ctx, ".data"},     int'(data_out),  m_data);
        chk({ctx, ".grant_ch"}, int'(grant_ch),  m_ch);
        chk({ctx, ".slot_idx"}, int'(slot_idx),  m_slot);
    endtask

    task automatic cycle(input string ctx);
        logic [NCH-1:0] empty_at_edge;
        empty_at_edge = empty;
        model_step();
        @(posedge clk0);
        #1;
        compare_all(ctx);
        chk({ctx, ".pop_of_empty"}, int'(pop & empty_at_edge), 0);
        chk({ctx, ".pop_multi"}, int'($countones(pop) > 1), 0);
    endtask

    task automatic async_reset_pulse(input string ctx);
        rst = 1'b1;
        #1;
        chk({ctx, ".rst_pop"},   int'(pop), 0);
        chk({ctx, ".rst_valid"}, int'(valid_out), 0);
        chk({ctx, ".rst_data"},  int'(data_out), 0);
        chk({ctx, ".rst_ch"},    int'(grant_ch), 0);
        chk({ctx, ".rst_slot"},  int'(slot_idx), 0);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [DEPTH*CW-1:0] pack_tbl(input int t [DEPTH]);
        logic [DEPTH*CW-1:0] v = '0;
        for (int k = 0; k < DEPTH; k++) v[k*CW +: CW] = CW'(t[k]);
        return v;
    endfunction

    int custom_tbl [DEPTH]  = '{2, 0, 1, 2, 1, 2, 3, 2};
    int default_tbl [DEPTH] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_ch [6]   = '{2, 0, 2, 2, 3, 2};
    int exp_slot [6] = '{0, 1, 3, 5, 6, 7};

    initial begin
        model_reset();
        #2;
        compare_all("reset");
        @(posedge clk0);
        #1;
        rst = 1'b0;

        // default table: plain rotation over a,b,c,d
        data_in   = {4'hd, 4'hc, 4'hb, 4'ha};
        empty     = 4'b0000;
        out_ready = 1'b1;
        enb       = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle("rot");
            chk("rot_data", int'(data_out), 'ha + (k % 4));
            chk("rot_slot", int'(slot_idx), k % 8);
        end

        async_reset_pulse("midrun");
        cycle("first_grant");
        chk("first_grant_valid", int'(valid_out), 1);
        chk("first_grant_slot", int'(slot_idx), 0);

        // custom table with channel 1 empty
        init     = 1'b1;
        table_in = pack_tbl(custom_tbl);
        empty    = 4'b0010;
        cycle("init_custom");
        chk("init_valid", int'(valid_out), 0);
        init = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle("skip");
            chk("skip_ch", int'(grant_ch), exp_ch[k]);
            chk("skip_slot", int'(slot_idx), exp_slot[k]);
            chk("skip_pop1", int'(pop[1]), 0);
        end

        // all channels empty, then only channel 3 has data
        empty = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle("all_empty");
            chk("all_empty_valid", int'(valid_out), 0);
        end
        empty = 4'b0111;
        cycle("wake");
        chk("wake_ch", int'(grant_ch), 3);
        chk("wake_slot", int'(slot_idx), 6);

        // backpressure on the channel-3 word
        empty     = 4'b0000;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp");
            chk("bp_hold", int'(data_out), 'hd);
            chk("bp_pop", int'(pop), 0);
        end
        out_ready = 1'b1;
        cycle("bp_release");
        chk("bp_resume_slot", int'(slot_idx), 7);
        chk("bp_resume_ch", int'(grant_ch), 2);

        // init while stalled drops the pending word
        out_ready = 1'b0;
        cycle("stall");
        init     = 1'b1;
        table_in = pack_tbl(default_tbl);
        cycle("init_stall");
        chk("init_stall_valid", int'(valid_out), 0);
        init      = 1'b0;
        out_ready = 1'b1;
        cycle("after_init");
        chk("after_init_slot", int'(slot_idx), 0);
        chk("after_init_ch", int'(grant_ch), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            enb       = ($urandom_range(0, 9) != 0);
            init      = ($urandom_range(0, 39) == 0);
            if (init) table_in = 16'($urandom);
            data_in   = 16'($urandom);
            empty     = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) async_reset_pulse("rand");
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
